// File: rtl/mastermind_pkg.sv
// rtl/mastermind_pkg.sv - shared parameters, state encoding and slot helpers for the scorer
package mastermind_pkg;

  localparam int CW          = 3;
  localparam int SLOTS       = 4;
  localparam int NUM_COLORS  = 6;
  localparam int MAX_GUESSES = 6;

  localparam int CODE_W = SLOTS * CW;
  localparam int POS_W  = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int CNT_W  = 3;

  localparam logic [POS_W-1:0] LAST_POS  = POS_W'(SLOTS - 1);
  localparam logic [CW-1:0]    LAST_COL  = CW'(NUM_COLORS - 1);
  localparam logic [CNT_W-1:0] SLOTS_CNT = CNT_W'(SLOTS);
  localparam logic [CNT_W-1:0] MAX_CNT   = CNT_W'(MAX_GUESSES);

  typedef enum logic [2:0] {IDLE, EXACT, COLOR, DONE, OVER} state_t;

  // Colour code held in slot idx of a packed code word (slot0 in the LSBs).
  function automatic logic [CW-1:0] slot_of(input logic [CODE_W-1:0] word,
                                            input logic [POS_W-1:0]  idx);
    return word[idx*CW +: CW];
  endfunction

  function automatic logic code_legal(input logic [CW-1:0] code);
    return 32'(code) < NUM_COLORS;
  endfunction

  // A code word is legal only if every slot holds a legal colour.
  function automatic logic word_legal(input logic [CODE_W-1:0] word);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < SLOTS; i++) begin
      if (!code_legal(word[i*CW +: CW])) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/mastermind_color_hist.sv
// rtl/mastermind_color_hist.sv - per-colour occurrence counters for one code word
module mastermind_color_hist
  import mastermind_pkg::*;
(
  input  logic             CLK,
  input  logic             RESET,
  input  logic             clear,
  input  logic             inc,
  input  logic [CW-1:0]    inc_code,
  input  logic [CW-1:0]    rd_col,
  output logic [CNT_W-1:0] rd_cnt
);

  logic [CNT_W-1:0] cnt [NUM_COLORS];

  // Count one occurrence per inc; clear has priority and illegal codes never count.
  always_ff @(posedge CLK) begin
    if (!RESET || clear) begin
      for (int c = 0; c < NUM_COLORS; c++) cnt[c] <= '0;
    end else if (inc && code_legal(inc_code)) begin
      cnt[inc_code] <= cnt[inc_code] + CNT_W'(1);
    end
  end

  // Read port; out-of-range columns read as zero.
  always_comb begin
    rd_cnt = '0;
    if (code_legal(rd_col)) rd_cnt = cnt[rd_col];
  end

endmodule

// File: rtl/mastermind_scorer.sv
// rtl/mastermind_scorer.sv - black/white scoring engine with guess count and win/lose tracking
module mastermind_scorer
  import mastermind_pkg::*;
(
  input  logic              CLK,
  input  logic              RESET,
  input  logic              load_secret,
  input  logic [CODE_W-1:0] secret_in,
  input  logic              start,
  input  logic [CODE_W-1:0] guess_in,
  output logic              busy,
  output logic              secret_valid,
  output logic              score_valid,
  output logic [CNT_W-1:0]  black_cnt,
  output logic [CNT_W-1:0]  white_cnt,
  output logic [CNT_W-1:0]  guess_count,
  output logic              win,
  output logic              lose,
  output logic              game_over
);

  state_t            state, next_state;
  logic [CODE_W-1:0] secret_q, guess_q;
  logic [POS_W-1:0]  pos;
  logic [CW-1:0]     col;
  logic [CNT_W-1:0]  black_acc, total_acc;
  logic              secret_ok, do_load, do_start, exact_step;
  logic [CW-1:0]     g_code, s_code;
  logic [CNT_W-1:0]  g_rd, s_rd, min_rd, next_count;
  logic              final_win, final_lose;

  assign secret_ok  = word_legal(secret_in);
  assign g_code     = slot_of(guess_q, pos);
  assign s_code     = slot_of(secret_q, pos);
  assign min_rd     = (g_rd < s_rd) ? g_rd : s_rd;
  assign next_count = (guess_count == MAX_CNT) ? guess_count : guess_count + CNT_W'(1);
  assign final_win  = (black_acc == SLOTS_CNT);
  assign final_lose = !final_win && (next_count == MAX_CNT);
  assign busy       = (state == EXACT) || (state == COLOR) || (state == DONE);
  assign game_over  = win | lose;

  mastermind_color_hist u_guess_hist (
    .CLK      (CLK),
    .RESET    (RESET),
    .clear    (do_start),
    .inc      (exact_step),
    .inc_code (g_code),
    .rd_col   (col),
    .rd_cnt   (g_rd)
  );

  mastermind_color_hist u_secret_hist (
    .CLK      (CLK),
    .RESET    (RESET),
    .clear    (do_start),
    .inc      (exact_step),
    .inc_code (s_code),
    .rd_col   (col),
    .rd_cnt   (s_rd)
  );

  // State register.
  always_ff @(posedge CLK) begin
    if (!RESET) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state and command decode; load_secret always shadows start.
  always_comb begin
    next_state = state;
    do_load    = 1'b0;
    do_start   = 1'b0;
    exact_step = 1'b0;
    unique case (state)
      IDLE: begin
        if (load_secret) begin
          do_load = secret_ok;
        end else if (start && secret_valid) begin
          do_start   = 1'b1;
          next_state = EXACT;
        end
      end
      EXACT: begin
        exact_step = 1'b1;
        if (pos == LAST_POS) next_state = COLOR;
      end
      COLOR: begin
        if (col == LAST_COL) next_state = DONE;
      end
      DONE: begin
        next_state = (final_win || final_lose) ? OVER : IDLE;
      end
      OVER: begin
        if (load_secret && secret_ok) begin
          do_load    = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Datapath: secret/guess latches, accumulators, score and game status.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      secret_q     <= '0;
      guess_q      <= '0;
      pos          <= '0;
      col          <= '0;
      black_acc    <= '0;
      total_acc    <= '0;
      secret_valid <= 1'b0;
      score_valid  <= 1'b0;
      black_cnt    <= '0;
      white_cnt    <= '0;
      guess_count  <= '0;
      win          <= 1'b0;
      lose         <= 1'b0;
    end else begin
      score_valid <= 1'b0;
      if (do_load) begin
        secret_q     <= secret_in;
        secret_valid <= 1'b1;
        guess_count  <= '0;
        win          <= 1'b0;
        lose         <= 1'b0;
      end
      if (do_start) begin
        guess_q   <= guess_in;
        black_acc <= '0;
        total_acc <= '0;
        pos       <= '0;
        col       <= '0;
      end
      if (exact_step) begin
        pos <= pos + POS_W'(1);
        if ((g_code == s_code) && code_legal(g_code)) black_acc <= black_acc + CNT_W'(1);
      end
      if (state == COLOR) begin
        total_acc <= total_acc + min_rd;
        col       <= col + CW'(1);
      end
      if (state == DONE) begin
        black_cnt   <= black_acc;
        white_cnt   <= total_acc - black_acc;
        score_valid <= 1'b1;
        guess_count <= next_count;
        if (final_win)       win  <= 1'b1;
        else if (final_lose) lose <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mastermind_scorer.sv
// tb/tb_mastermind_scorer.sv - self-checking bench for mastermind_scorer
module tb_mastermind_scorer;

  localparam int CW   = 3;
  localparam int SL   = 4;
  localparam int NC   = 6;
  localparam int MAXG = 6;
  localparam int LAT  = SL + NC + 1;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        load_secret = 1'b0;
  logic        start = 1'b0;
  logic [11:0] secret_in = '0;
  logic [11:0] guess_in = '0;
  logic        busy, secret_valid, score_valid, win, lose, game_over;
  logic [2:0]  black_cnt, white_cnt, guess_count;

  int total = 0;
  int bad = 0;

  mastermind_scorer dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .load_secret  (load_secret),
    .secret_in    (secret_in),
    .start        (start),
    .guess_in     (guess_in),
    .busy         (busy),
    .secret_valid (secret_valid),
    .score_valid  (score_valid),
    .black_cnt    (black_cnt),
    .white_cnt    (white_cnt),
    .guess_count  (guess_count),
    .win          (win),
    .lose         (lose),
    .game_over    (game_over)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [11:0] secret;
    logic [11:0] guess;
    int          blk;
    int          wht;
  } vec_t;

  vec_t vecs [8];

  function automatic logic [11:0] pack4(input int s0, input int s1, input int s2, input int s3);
    return {3'(s3), 3'(s2), 3'(s1), 3'(s0)};
  endfunction

  // Reference: black = same colour in same slot; white = sum over colours of the
  // smaller occurrence count, minus black. Codes outside 0..NC-1 never count.
  function automatic void ref_score(input logic [11:0] sec, input logic [11:0] gue,
                                    output int b, output int w);
    int gh [NC];
    int sh [NC];
    int tot, g, s;
    b = 0;
    tot = 0;
    for (int c = 0; c < NC; c++) begin
      gh[c] = 0;
      sh[c] = 0;
    end
    for (int i = 0; i < SL; i++) begin
      g = int'(gue[i*CW +: CW]);
      s = int'(sec[i*CW +: CW]);
      if (g < NC && g == s) b++;
      if (g < NC) gh[g]++;
      if (s < NC) sh[s]++;
    end
    for (int c = 0; c < NC; c++) tot += (gh[c] < sh[c]) ? gh[c] : sh[c];
    w = tot - b;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic load(input logic [11:0] s);
    secret_in   = s;
    load_secret = 1'b1;
    tick();
    load_secret = 1'b0;
  endtask

  // Pulse start and wait (bounded) for score_valid; counts edges and busy cycles.
  task automatic run_guess(input logic [11:0] g, output int lat, output int bcyc, output bit got);
    guess_in = g;
    start    = 1'b1;
    tick();
    start = 1'b0;
    lat  = 0;
    bcyc = 0;
    got  = 1'b0;
    while (lat < 40 && !got) begin
      if (busy) bcyc++;
      tick();
      lat++;
      if (score_valid) got = 1'b1;
    end
  endtask

  task automatic score_check(input string tag, input logic [11:0] g, input int eb, input int ew);
    int lat, bcyc;
    bit got;
    run_guess(g, lat, bcyc, got);
    check({tag, " score_valid seen"}, int'(got), 1);
    if (got) begin
      check({tag, " latency"}, lat, LAT);
      check({tag, " busy cycles"}, bcyc, LAT);
      check({tag, " black"}, int'(black_cnt), eb);
      check({tag, " white"}, int'(white_cnt), ew);
    end
  endtask

  // Watch n cycles starting now; report how many had score_valid / busy high.
  task automatic quiet(input int n, output int sv, output int bz);
    sv = 0;
    bz = 0;
    for (int i = 0; i < n; i++) begin
      if (score_valid) sv++;
      if (busy) bz++;
      tick();
    end
  endtask

  initial begin
    int sv, bz, lat, bcyc, eb, ew;
    int m_gc;
    bit m_win, m_lose, got;
    logic [11:0] rs, rg;

    vecs[0] = '{pack4(0,1,2,3), pack4(0,1,2,3), 4, 0};
    vecs[1] = '{pack4(0,1,2,3), pack4(3,2,1,0), 0, 4};
    vecs[2] = '{pack4(1,1,2,2), pack4(1,2,1,5), 1, 2};
    vecs[3] = '{pack4(0,1,2,3), pack4(7,7,6,0), 0, 1};
    vecs[4] = '{pack4(5,5,5,5), pack4(5,0,5,0), 2, 0};
    vecs[5] = '{pack4(2,3,4,5), pack4(5,4,3,2), 0, 4};
    vecs[6] = '{pack4(0,0,0,0), pack4(7,7,7,7), 0, 0};
    vecs[7] = '{pack4(3,3,1,0), pack4(3,1,3,3), 1, 2};

    // Reset state
    RESET = 1'b0;
    repeat (3) tick();
    check("rst busy", int'(busy), 0);
    check("rst secret_valid", int'(secret_valid), 0);
    check("rst score_valid", int'(score_valid), 0);
    check("rst black", int'(black_cnt), 0);
    check("rst white", int'(white_cnt), 0);
    check("rst guess_count", int'(guess_count), 0);
    check("rst win", int'(win), 0);
    check("rst lose", int'(lose), 0);
    check("rst game_over", int'(game_over), 0);
    RESET = 1'b1;
    tick();

    // start with no secret is ignored
    guess_in = pack4(0,1,2,3);
    start = 1'b1;
    tick();
    start = 1'b0;
    quiet(15, sv, bz);
    check("nosecret busy", bz, 0);
    check("nosecret score_valid", sv, 0);

    // illegal secret from reset is ignored
    load(pack4(6,0,0,0));
    check("illegal load secret_valid", int'(secret_valid), 0);

    // load_secret and start together: load wins
    secret_in = pack4(0,1,2,3);
    guess_in  = pack4(0,1,2,3);
    load_secret = 1'b1;
    start = 1'b1;
    tick();
    load_secret = 1'b0;
    start = 1'b0;
    check("load+start secret_valid", int'(secret_valid), 1);
    quiet(15, sv, bz);
    check("load+start busy", bz, 0);
    check("load+start score_valid", sv, 0);

    // Directed table
    for (int i = 0; i < 8; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      load(vecs[i].secret);
      check({tag, " guess_count after load"}, int'(guess_count), 0);
      check({tag, " game_over after load"}, int'(game_over), 0);
      score_check(tag, vecs[i].guess, vecs[i].blk, vecs[i].wht);
      check({tag, " guess_count"}, int'(guess_count), 1);
      check({tag, " win"}, int'(win), (vecs[i].blk == SL) ? 1 : 0);
      check({tag, " game_over"}, int'(game_over), (vecs[i].blk == SL) ? 1 : 0);
      tick();
      check({tag, " score_valid one cycle"}, int'(score_valid), 0);
      check({tag, " busy after done"}, int'(busy), 0);
    end

    // Illegal load keeps old secret; OVER ignores start and illegal loads
    load(pack4(0,1,2,3));
    load(pack4(6,0,0,0));
    check("illegal reload secret_valid", int'(secret_valid), 1);
    score_check("keep secret", pack4(0,1,2,3), 4, 0);
    check("keep secret win", int'(win), 1);
    guess_in = pack4(3,2,1,0);
    start = 1'b1;
    tick();
    start = 1'b0;
    quiet(15, sv, bz);
    check("over start busy", bz, 0);
    check("over start score_valid", sv, 0);
    load(pack4(0,0,0,7));
    check("over illegal load game_over", int'(game_over), 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    quiet(15, sv, bz);
    check("over after illegal load score_valid", sv, 0);

    // start / load_secret while busy are dropped
    load(pack4(0,1,2,3));
    guess_in = pack4(3,2,1,0);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    guess_in = pack4(0,1,2,3);
    start = 1'b1;
    tick();
    start = 1'b0;
    secret_in = pack4(5,5,5,5);
    load_secret = 1'b1;
    tick();
    load_secret = 1'b0;
    lat = 0;
    got = 1'b0;
    while (lat < 40 && !got) begin
      tick();
      lat++;
      if (score_valid) got = 1'b1;
    end
    check("busy-drop score_valid seen", int'(got), 1);
    check("busy-drop black", int'(black_cnt), 0);
    check("busy-drop white", int'(white_cnt), 4);
    check("busy-drop guess_count", int'(guess_count), 1);
    tick();
    quiet(15, sv, bz);
    check("busy-drop no queued score", sv, 0);
    score_check("busy-drop secret kept", pack4(5,5,5,5), 0, 0);

    // Lose after MAX_GUESSES misses
    load(pack4(0,1,2,3));
    for (int k = 1; k <= MAXG; k++) begin
      string tag;
      tag = $sformatf("miss%0d", k);
      score_check(tag, pack4(4,4,4,4), 0, 0);
      check({tag, " guess_count"}, int'(guess_count), k);
      check({tag, " lose"}, int'(lose), (k == MAXG) ? 1 : 0);
      check({tag, " game_over"}, int'(game_over), (k == MAXG) ? 1 : 0);
    end
    guess_in = pack4(0,1,2,3);
    start = 1'b1;
    tick();
    start = 1'b0;
    quiet(15, sv, bz);
    check("seventh busy", bz, 0);
    check("seventh score_valid", sv, 0);
    check("seventh guess_count", int'(guess_count), MAXG);
    load(pack4(1,2,3,4));
    check("reload guess_count", int'(guess_count), 0);
    check("reload lose", int'(lose), 0);
    check("reload game_over", int'(game_over), 0);

    // Randomized games against the reference model
    rs = pack4($urandom_range(0,5), $urandom_range(0,5), $urandom_range(0,5), $urandom_range(0,5));
    load(rs);
    m_gc = 0;
    m_win = 1'b0;
    m_lose = 1'b0;
    for (int n = 0; n < 60; n++) begin
      string tag;
      tag = $sformatf("rnd%0d", n);
      if ($urandom_range(0,3) == 0) rg = rs;
      else rg = pack4($urandom_range(0,7), $urandom_range(0,7), $urandom_range(0,7), $urandom_range(0,7));
      ref_score(rs, rg, eb, ew);
      score_check(tag, rg, eb, ew);
      m_gc++;
      if (eb == SL) m_win = 1'b1;
      else if (m_gc == MAXG) m_lose = 1'b1;
      check({tag, " guess_count"}, int'(guess_count), m_gc);
      check({tag, " win"}, int'(win), int'(m_win));
      check({tag, " lose"}, int'(lose), int'(m_lose));
      tick();
      if (m_win || m_lose || $urandom_range(0,7) == 0) begin
        rs = pack4($urandom_range(0,5), $urandom_range(0,5), $urandom_range(0,5), $urandom_range(0,5));
        load(rs);
        m_gc = 0;
        m_win = 1'b0;
        m_lose = 1'b0;
      end
    end

    // Reset during the third EXACT cycle aborts scoring
    load(pack4(0,1,2,3));
    score_check("pre-reset", pack4(0,1,3,2), 2, 2);
    guess_in = pack4(0,1,2,3);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    RESET = 1'b0;
    tick();
    RESET = 1'b1;
    check("midrst busy", int'(busy), 0);
    check("midrst secret_valid", int'(secret_valid), 0);
    check("midrst black", int'(black_cnt), 0);
    check("midrst white", int'(white_cnt), 0);
    check("midrst guess_count", int'(guess_count), 0);
    check("midrst score_valid", int'(score_valid), 0);
    quiet(15, sv, bz);
    check("midrst no score_valid", sv, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    quiet(15, sv, bz);
    check("midrst start busy", bz, 0);
    check("midrst start score_valid", sv, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
